// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: shared FSM encoding, width defaults and grant-select constants
package mem_port_arbiter_pkg;
  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;
  typedef logic [1:0] state_t;
  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] SERVE_DM = 2'd1;
  localparam logic [1:0] SERVE_IF = 2'd2;
  localparam logic [1:0] RESP     = 2'd3;
  localparam logic GNT_DM = 1'b0;
  localparam logic GNT_IF = 1'b1;
endpackage

// File: rtl/mem_arb_perf_counter.sv
// mem_arb_perf_counter: 32-bit saturating event counter with enable
module mem_arb_perf_counter (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        en_i,
  output logic [31:0] count_o
);
  // count enabled cycles, sticking at all-ones instead of wrapping
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) count_o <= '0;
    else if (en_i && count_o != '1) count_o <= count_o + 32'd1;
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: serialises IF fetch and MEM data access onto one memory port; MEM_ARB_PERF_EN adds wait-cycle counters
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  input  logic              if_kill_i,
  output logic [DATA_W-1:0] if_rdata_o,
  output logic              if_ack_o,
  input  logic              dm_req_i,
  input  logic              dm_we_i,
  input  logic [ADDR_W-1:0] dm_addr_i,
  input  logic [DATA_W-1:0] dm_wdata_i,
  output logic [DATA_W-1:0] dm_rdata_o,
  output logic              dm_ack_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic              mem_ready_i,
  output logic              stall_o
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [31:0]       perf_if_wait_o,
  output logic [31:0]       perf_dm_wait_o
`endif
);
  state_t state, nxt;
  logic   gnt, kill_flag;

  // data wins in IDLE (older instruction); a grant holds until memory completes; RESP always returns to IDLE
  always_comb
    nxt = state == IDLE ? (dm_req_i ? SERVE_DM : (if_req_i && !if_kill_i) ? SERVE_IF : IDLE)
        : state == RESP ? IDLE
        : mem_ready_i   ? RESP : state;

  // FSM, grant capture at entry, read-data capture on completion, kill flag for in-flight fetches
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) begin
      state       <= IDLE;
      gnt         <= GNT_DM;
      kill_flag   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      if_rdata_o  <= '0;
      dm_rdata_o  <= '0;
    end else begin
      state     <= nxt;
      kill_flag <= state == RESP ? 1'b0 : kill_flag | (state == SERVE_IF && if_kill_i);
      if (state == IDLE && nxt != IDLE) begin
        gnt         <= dm_req_i ? GNT_DM : GNT_IF;
        mem_we_o    <= dm_req_i & dm_we_i;
        mem_addr_o  <= dm_req_i ? dm_addr_i : if_addr_i;
        mem_wdata_o <= dm_req_i ? dm_wdata_i : '0;
      end
      if (state == SERVE_IF && mem_ready_i) if_rdata_o <= mem_rdata_i;
      if (state == SERVE_DM && mem_ready_i && !mem_we_o) dm_rdata_o <= mem_rdata_i;
    end

  assign mem_req_o = state == SERVE_DM || state == SERVE_IF;
  assign if_ack_o  = state == RESP && gnt == GNT_IF && !kill_flag;
  assign dm_ack_o  = state == RESP && gnt == GNT_DM;
  // gated by reset so the pipeline is released the instant reset asserts
  assign stall_o   = rst_i && ((if_req_i && !if_ack_o && !if_kill_i) || (dm_req_i && !dm_ack_o));

`ifdef MEM_ARB_PERF_EN
  mem_arb_perf_counter u_perf_if (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .en_i    (if_req_i && !if_ack_o),
    .count_o (perf_if_wait_o)
  );
  mem_arb_perf_counter u_perf_dm (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .en_i    (dm_req_i && !dm_ack_o),
    .count_o (perf_dm_wait_o)
  );
`endif
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: vector table, corner sequences and random transactions against a transaction-level model
module tb_mem_port_arbiter;
  logic        clk = 1'b0, rst_i = 1'b0;
  logic        if_req = 1'b0, if_kill = 1'b0, dm_req = 1'b0, dm_we = 1'b0;
  logic [31:0] if_addr = '0, dm_addr = '0, dm_wdata = '0;
  logic [31:0] if_rdata_o, dm_rdata_o, mem_addr_o, mem_wdata_o;
  logic        if_ack_o, dm_ack_o, mem_req_o, mem_we_o, stall_o;
  logic [31:0] mem_rdata = '0;
  logic        mem_ready = 1'b0;
`ifdef MEM_ARB_PERF_EN
  logic [31:0] perf_if, perf_dm;
`endif
  int n_tot = 0, n_bad = 0;
  int wait_if = 0, wait_dm = 0;
  logic [31:0] mem [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] prev_dr = '0;

  mem_port_arbiter dut (
    .clk_i(clk), .rst_i(rst_i),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_kill_i(if_kill),
    .if_rdata_o(if_rdata_o), .if_ack_o(if_ack_o),
    .dm_req_i(dm_req), .dm_we_i(dm_we), .dm_addr_i(dm_addr), .dm_wdata_i(dm_wdata),
    .dm_rdata_o(dm_rdata_o), .dm_ack_o(dm_ack_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata), .mem_ready_i(mem_ready),
    .stall_o(stall_o)
`ifdef MEM_ARB_PERF_EN
    , .perf_if_wait_o(perf_if), .perf_dm_wait_o(perf_dm)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [31:0] rd_mem(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : dflt(a);
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
  endfunction

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    n_tot++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", n, a, e);
    end
  endtask

  task automatic chk1(input string n, input logic a, input logic e);
    n_tot++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %b want %b", n, a, e);
    end
  endtask

  // memory model: addresses >= 0x100 use the data wait count, others the fetch wait count
  int          wcnt = 0;
  logic [31:0] h_addr, h_wdata;
  logic        h_we;
  always @(negedge clk) begin
    if (mem_req_o) begin
      if (wcnt == 0) begin
        h_addr = mem_addr_o; h_we = mem_we_o; h_wdata = mem_wdata_o;
      end else begin
        n_tot++;
        if (mem_addr_o !== h_addr || mem_we_o !== h_we || mem_wdata_o !== h_wdata) begin
          n_bad++;
          $display("FAIL hold: got %h/%b/%h want %h/%b/%h", mem_addr_o, mem_we_o, mem_wdata_o, h_addr, h_we, h_wdata);
        end
      end
      if (wcnt == (mem_addr_o >= 32'h100 ? wait_dm : wait_if)) begin
        mem_ready = 1'b1;
        mem_rdata = h_we ? $urandom : rd_mem(h_addr);
        if (h_we) mem[h_addr] = h_wdata;
        wcnt = 0;
      end else begin
        mem_ready = 1'b0;
        mem_rdata = $urandom;
        wcnt++;
      end
    end else begin
      mem_ready = 1'b0;
      mem_rdata = $urandom;
      wcnt = 0;
    end
  end

  // one transaction round from IDLE; latencies are cycle indices of the ack counted from request cycle 0
  task automatic txn(input bit ion, input bit don, input bit we,
                     input logic [31:0] ia, input logic [31:0] da, input logic [31:0] wdat,
                     input int wi, input int wd,
                     output int ilat, output int dlat, output int scnt,
                     output logic [31:0] ir, output logic [31:0] dr);
    int spur;
    bit idrop, ddrop;
    wait_if = wi; wait_dm = wd;
    if_req = ion; if_addr = ia; dm_req = don; dm_we = we; dm_addr = da; dm_wdata = wdat;
    ilat = -1; dlat = -1; scnt = 0; spur = 0; ir = '0; dr = '0;
    for (int c = 0; c < 100 && ((ion && ilat < 0) || (don && dlat < 0)); c++) begin
      @(negedge clk);
      idrop = 0; ddrop = 0;
      if (stall_o) scnt++;
      if (if_ack_o) begin
        if (!ion || ilat >= 0) spur++;
        else begin ilat = c; ir = if_rdata_o; idrop = 1; end
      end
      if (dm_ack_o) begin
        if (!don || dlat >= 0) spur++;
        else begin dlat = c; dr = dm_rdata_o; ddrop = 1; end
      end
      @(posedge clk); #1;
      if (idrop) if_req = 1'b0;
      if (ddrop) dm_req = 1'b0;
    end
    chk("spurious_ack", spur, 0);
  endtask

  typedef struct {
    bit ion, don, we;
    logic [31:0] ia, da, wdat;
    int wi, wd, eil, edl;
    logic [31:0] eir, edr;
  } vec_t;

  initial begin
    vec_t vecs [7];
    int ilat, dlat, scnt, lat, acks;
    logic [31:0] ir, dr;
    vecs[0] = '{1, 0, 0, 32'h10, 32'h0,   32'h0,        0, 0, 2, 0, 32'h8C220004, 32'h0};
    vecs[1] = '{1, 1, 0, 32'h20, 32'h100, 32'h0,        2, 2, 9, 4, 32'h8C220008, 32'hCAFE0100};
    vecs[2] = '{0, 1, 1, 32'h0,  32'h200, 32'hDEADBEEF, 0, 1, 0, 3, 32'h0,        32'hCAFE0100};
    vecs[3] = '{0, 1, 0, 32'h0,  32'h200, 32'h0,        0, 0, 0, 2, 32'h0,        32'hDEADBEEF};
    vecs[4] = '{1, 1, 1, 32'h10, 32'h104, 32'h01020304, 1, 0, 6, 2, 32'h8C220004, 32'hDEADBEEF};
    vecs[5] = '{0, 1, 0, 32'h0,  32'h104, 32'h0,        0, 3, 0, 5, 32'h0,        32'h01020304};
    vecs[6] = '{1, 0, 0, 32'h24, 32'h0,   32'h0,        4, 0, 6, 0, 32'h5A5A0024, 32'h0};
    mem[32'h10] = 32'h8C220004; ref_mem[32'h10] = 32'h8C220004;
    mem[32'h20] = 32'h8C220008; ref_mem[32'h20] = 32'h8C220008;
    mem[32'h100] = 32'hCAFE0100; ref_mem[32'h100] = 32'hCAFE0100;

    repeat (3) @(posedge clk);
    #1;
    chk1("rst_mem_req", mem_req_o, 1'b0);
    chk1("rst_mem_we", mem_we_o, 1'b0);
    chk("rst_mem_addr", mem_addr_o, 32'h0);
    chk("rst_mem_wdata", mem_wdata_o, 32'h0);
    chk1("rst_if_ack", if_ack_o, 1'b0);
    chk1("rst_dm_ack", dm_ack_o, 1'b0);
    chk("rst_if_rdata", if_rdata_o, 32'h0);
    chk("rst_dm_rdata", dm_rdata_o, 32'h0);
    chk1("rst_stall", stall_o, 1'b0);
    rst_i = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 7; i++) begin
      txn(vecs[i].ion, vecs[i].don, vecs[i].we, vecs[i].ia, vecs[i].da, vecs[i].wdat,
          vecs[i].wi, vecs[i].wd, ilat, dlat, scnt, ir, dr);
      if (vecs[i].ion) begin
        chk($sformatf("vec%0d_if_lat", i), ilat, vecs[i].eil);
        chk($sformatf("vec%0d_if_rdata", i), ir, vecs[i].eir);
      end
      if (vecs[i].don) begin
        chk($sformatf("vec%0d_dm_lat", i), dlat, vecs[i].edl);
        chk($sformatf("vec%0d_dm_rdata", i), dr, vecs[i].edr);
      end
      chk($sformatf("vec%0d_stall_cycles", i), scnt, vecs[i].ion ? vecs[i].eil : vecs[i].edl);
      if (vecs[i].don) begin
        if (vecs[i].we) ref_mem[vecs[i].da] = vecs[i].wdat;
        else prev_dr = vecs[i].edr;
      end
    end
    chk("mem_wr_200", rd_mem(32'h200), 32'hDEADBEEF);

    // fetch killed while the memory access is in flight: access finishes, no ack, data still captured
    wait_if = 3; if_addr = 32'h40; if_req = 1'b1;
    @(posedge clk); #1;
    if_kill = 1'b1;
    @(posedge clk); #1;
    if_kill = 1'b0; if_req = 1'b0;
    acks = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (if_ack_o) acks++;
    end
    chk("kill_no_ack", acks, 0);
    chk1("kill_mem_idle", mem_req_o, 1'b0);
    chk("kill_if_rdata", if_rdata_o, 32'h5A5A0040);
    @(posedge clk); #1;
    txn(1, 0, 0, 32'h44, 32'h0, 32'h0, 0, 0, ilat, dlat, scnt, ir, dr);
    chk("post_kill_lat", ilat, 2);
    chk("post_kill_rdata", ir, 32'h5A5A0044);

    // kill in IDLE holds off the fetch for that cycle only
    wait_if = 0; if_addr = 32'h48; if_req = 1'b1; if_kill = 1'b1;
    @(posedge clk); #1;
    if_kill = 1'b0;
    lat = -1;
    for (int c = 1; c < 20 && lat < 0; c++) begin
      @(negedge clk);
      if (if_ack_o) lat = c;
      @(posedge clk); #1;
    end
    if_req = 1'b0;
    chk("kill_idle_lat", lat, 3);

    // asynchronous reset in the middle of a data grant
    wait_dm = 10; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h108;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    chk1("pre_rst_mem_req", mem_req_o, 1'b1);
    rst_i = 1'b0;
    #1;
    chk1("mid_rst_mem_req", mem_req_o, 1'b0);
    chk1("mid_rst_dm_ack", dm_ack_o, 1'b0);
    chk1("mid_rst_stall", stall_o, 1'b0);
    chk("mid_rst_mem_addr", mem_addr_o, 32'h0);
    dm_req = 1'b0;
    @(posedge clk); #1;
    rst_i = 1'b1;
    prev_dr = '0;
    @(posedge clk); #1;
    txn(0, 1, 0, 32'h0, 32'h108, 32'h0, 0, 0, ilat, dlat, scnt, ir, dr);
    chk("post_rst_dm_lat", dlat, 2);
    chk("post_rst_dm_rdata", dr, 32'h5A5A0108);
    prev_dr = 32'h5A5A0108;

`ifdef MEM_ARB_PERF_EN
    begin
      logic [31:0] p0;
      p0 = perf_dm;
      txn(0, 1, 0, 32'h0, 32'h10C, 32'h0, 0, 5, ilat, dlat, scnt, ir, dr);
      chk("perf_dm_delta", perf_dm - p0, 32'd7);
      prev_dr = 32'h5A5A010C;
      p0 = perf_if;
      txn(1, 0, 0, 32'h4C, 32'h0, 32'h0, 2, 0, ilat, dlat, scnt, ir, dr);
      chk("perf_if_delta", perf_if - p0, 32'd4);
    end
`endif

    // random transactions against the transaction-level model
    for (int i = 0; i < 40; i++) begin
      bit ion, don, we;
      logic [31:0] ia, da, wdat, er_if, er_dm;
      int wi, wd, eil, edl;
      ion = 1'($urandom_range(0, 1));
      don = 1'($urandom_range(0, 1));
      if (!ion && !don) ion = 1'b1;
      we = 1'($urandom_range(0, 1));
      ia = 32'($urandom_range(0, 63)) << 2;
      da = 32'h100 + (32'($urandom_range(0, 15)) << 2);
      wdat = $urandom;
      wi = int'($urandom_range(0, 4));
      wd = int'($urandom_range(0, 4));
      edl = 2 + wd;
      eil = don ? edl + 3 + wi : 2 + wi;
      er_if = ref_rd(ia);
      er_dm = we ? prev_dr : ref_rd(da);
      txn(ion, don, we, ia, da, wdat, wi, wd, ilat, dlat, scnt, ir, dr);
      if (ion) begin
        chk($sformatf("rnd%0d_if_lat", i), ilat, eil);
        chk($sformatf("rnd%0d_if_rdata", i), ir, er_if);
      end
      if (don) begin
        chk($sformatf("rnd%0d_dm_lat", i), dlat, edl);
        chk($sformatf("rnd%0d_dm_rdata", i), dr, er_dm);
        if (we) ref_mem[da] = wdat;
        else prev_dr = er_dm;
      end
      chk($sformatf("rnd%0d_stall_cycles", i), scnt, ion ? eil : edl);
    end

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end
endmodule
